// File: rtl/cordic_host_sequencer.sv
// cordic_host_sequencer: queues operand requests, runs them one at a time through the CORDIC
// core's start/done handshake and returns results in order. CORDIC_SEQ_TIMEOUT_EN adds a watchdog.
module cordic_host_sequencer #(
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clka,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [DATA_W-1:0] req_x,
  input  logic [DATA_W-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_p0,
  output logic [DATA_W-1:0] rsp_p1,
  output logic              rsp_err,
  output logic              cordic_start,
  output logic              cordic_mode,
  output logic [DATA_W-1:0] cordic_port0,
  output logic [DATA_W-1:0] cordic_port1,
  output logic              cordic_reset,
  input  logic              cordic_done,
  input  logic [DATA_W-1:0] cordic_out0,
  input  logic [DATA_W-1:0] cordic_out1,
  output logic              busy
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              run_r;
  state_t            state_r;
  logic              start_r;
  logic              mode_r;
  logic [DATA_W-1:0] port0_r;
  logic [DATA_W-1:0] port1_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_p0_r;
  logic [DATA_W-1:0] rsp_p1_r;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [ENT_W-1:0]  head_s;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] timer_r;
  logic             rsp_err_r;
  logic             core_rst_r;
`endif

  // Queue status and handshake qualifiers, all decoded from registered state.
  always_comb begin
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == {CNT_W{1'b0}});
    push_s  = req_valid && run_r && !full_s;
    pop_s   = (state_r == ST_IDLE) && !empty_s;
    head_s  = fifo_mem_r[rd_ptr_r];
  end

  // Request queue storage, pointers and occupancy.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      run_r    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      run_r <= 1'b1;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {req_mode, req_x, req_y};
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Job sequencer: pop, launch, wait for done (or watchdog expiry), hold the response.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      start_r     <= 1'b0;
      mode_r      <= 1'b0;
      port0_r     <= '0;
      port1_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_p0_r    <= '0;
      rsp_p1_r    <= '0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
      timer_r     <= '0;
      rsp_err_r   <= 1'b0;
      core_rst_r  <= 1'b0;
`endif
    end else begin
      start_r <= 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
      core_rst_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            {mode_r, port0_r, port1_r} <= head_s;
            start_r <= 1'b1;
            state_r <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
`ifdef CORDIC_SEQ_TIMEOUT_EN
          timer_r <= '0;
`endif
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the expiry cycle still delivers the real result.
          if (cordic_done) begin
            rsp_p0_r    <= cordic_out0;
            rsp_p1_r    <= cordic_out1;
            rsp_valid_r <= 1'b1;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
`endif
            state_r     <= ST_RESP;
          end
`ifdef CORDIC_SEQ_TIMEOUT_EN
          else if (timer_r == TMR_LAST) begin
            rsp_p0_r    <= '0;
            rsp_p1_r    <= '0;
            rsp_err_r   <= 1'b1;
            core_rst_r  <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
`endif
            state_r     <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = run_r && !full_s;
  assign busy         = (state_r != ST_IDLE) || !empty_s;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_p0       = rsp_p0_r;
  assign rsp_p1       = rsp_p1_r;
  assign cordic_start = start_r;
  assign cordic_mode  = mode_r;
  assign cordic_port0 = port0_r;
  assign cordic_port1 = port1_r;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  assign rsp_err      = rsp_err_r;
  assign cordic_reset = core_rst_r;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
  assign rsp_err      = 1'b0;
  assign cordic_reset = 1'b0;
`endif

endmodule
